// File: rtl/instr_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_queue_pkg
// Description : Shared widths and constants for the instruction queue.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_queue_pkg;

    localparam int                IWIDTH    = 32;
    localparam int                IQ_DEPTH  = 4;
    localparam logic [IWIDTH-1:0] NOP_INSTR = 32'h0000_0000;

endpackage : instr_queue_pkg
`default_nettype wire

// File: rtl/instr_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_queue_if
// Description : Fetch/decode-side bus of the instruction queue.
//               iq_o_overflow exists only when IQ_OVERFLOW_CHK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_queue_if
    import instr_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) ();

    logic [IWIDTH-1:0]      iq_i_mem_instr;
    logic                   iq_i_mem_valid;
    logic                   iq_i_stall;
    logic                   iq_i_flush;
    logic [IWIDTH-1:0]      iq_o_instr;
    logic                   iq_o_check_queue;
    logic                   iq_o_full;
    logic [$clog2(DEPTH):0] iq_o_count;
`ifdef IQ_OVERFLOW_CHK_EN
    logic                   iq_o_overflow;

    modport master (
        output iq_i_mem_instr, iq_i_mem_valid, iq_i_stall, iq_i_flush,
        input  iq_o_instr, iq_o_check_queue, iq_o_full, iq_o_count, iq_o_overflow
    );
    modport slave (
        input  iq_i_mem_instr, iq_i_mem_valid, iq_i_stall, iq_i_flush,
        output iq_o_instr, iq_o_check_queue, iq_o_full, iq_o_count, iq_o_overflow
    );
`else
    modport master (
        output iq_i_mem_instr, iq_i_mem_valid, iq_i_stall, iq_i_flush,
        input  iq_o_instr, iq_o_check_queue, iq_o_full, iq_o_count
    );
    modport slave (
        input  iq_i_mem_instr, iq_i_mem_valid, iq_i_stall, iq_i_flush,
        output iq_o_instr, iq_o_check_queue, iq_o_full, iq_o_count
    );
`endif

endinterface : instr_queue_if
`default_nettype wire

// File: rtl/instr_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_queue
// Description : In-order instruction queue between instruction memory and
//               decode; bypassed when empty and decode is free.
//               Optional sticky overflow flag: define IQ_OVERFLOW_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  wire logic    iq_i_clk,
    input  wire logic    iq_i_rst,
    instr_queue_if.slave iq
);

    localparam int AWIDTH = $clog2(DEPTH);
    localparam int CWIDTH = AWIDTH + 1;
    localparam logic [CWIDTH-1:0] C_FULL_CNT = CWIDTH'(DEPTH);

    logic [IWIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CWIDTH-1:0] count_q,  count_d;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == C_FULL_CNT);
    assign w_pop   = !iq.iq_i_stall && !w_empty;
    // An empty queue with decode free is the bypass path: nothing is stored.
    assign w_push  = iq.iq_i_mem_valid && (iq.iq_i_stall || !w_empty) && (!w_full || w_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (iq.iq_i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (w_push && !w_pop)      count_d = count_q + 1'b1;
            else if (w_pop && !w_push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge iq_i_clk) begin
        if (!iq_i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= NOP_INSTR;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (w_push && !iq.iq_i_flush) mem_q[wr_ptr_q] <= iq.iq_i_mem_instr;
        end
    end

    assign iq.iq_o_instr       = w_empty ? NOP_INSTR : mem_q[rd_ptr_q];
    assign iq.iq_o_check_queue = !w_empty;
    assign iq.iq_o_full        = w_full;
    assign iq.iq_o_count       = count_q;

`ifdef IQ_OVERFLOW_CHK_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (w_full && iq.iq_i_stall && iq.iq_i_mem_valid && !iq.iq_i_flush) ovf_d = 1'b1;
    end

    always_ff @(posedge iq_i_clk) begin
        if (!iq_i_rst) ovf_q <= 1'b0;
        else           ovf_q <= ovf_d;
    end

    assign iq.iq_o_overflow = ovf_q;
`endif

endmodule : instr_queue
`default_nettype wire

// File: tb/tb_instr_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_queue
// Description : Directed self-checking bench for instr_queue (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_queue;
    import instr_queue_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    instr_queue_if #(.DEPTH(4)) iq_bus ();

    instr_queue #(.DEPTH(4)) dut (
        .iq_i_clk (clk),
        .iq_i_rst (rst_n),
        .iq       (iq_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic f, input logic [31:0] w);
        iq_bus.iq_i_mem_valid = v;
        iq_bus.iq_i_stall     = s;
        iq_bus.iq_i_flush     = f;
        iq_bus.iq_i_mem_instr = w;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        step();
        step();
        n_cmp++;
        if (iq_bus.iq_o_count !== 3'd0) begin
            n_err++; $display("FAIL reset_count: got %0d want 0", iq_bus.iq_o_count);
        end
        n_cmp++;
        if (iq_bus.iq_o_check_queue !== 1'b0) begin
            n_err++; $display("FAIL reset_check_queue: got %b want 0", iq_bus.iq_o_check_queue);
        end
        n_cmp++;
        if (iq_bus.iq_o_instr !== 32'h0) begin
            n_err++; $display("FAIL reset_instr: got %h want 0", iq_bus.iq_o_instr);
        end
        n_cmp++;
        if (iq_bus.iq_o_full !== 1'b0) begin
            n_err++; $display("FAIL reset_full: got %b want 0", iq_bus.iq_o_full);
        end
`ifdef IQ_OVERFLOW_CHK_EN
        n_cmp++;
        if (iq_bus.iq_o_overflow !== 1'b0) begin
            n_err++; $display("FAIL reset_overflow: got %b want 0", iq_bus.iq_o_overflow);
        end
`endif
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_bypass();
        logic [31:0] words [2];
        words[0] = 32'hAAAA_0001;
        words[1] = 32'hBBBB_0002;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, words[i]);
            step();
            n_cmp++;
            if (iq_bus.iq_o_count !== 3'd0 || iq_bus.iq_o_check_queue !== 1'b0) begin
                n_err++;
                $display("FAIL bypass_%0d: got count=%0d cq=%b want count=0 cq=0",
                         i, iq_bus.iq_o_count, iq_bus.iq_o_check_queue);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'(i * 32'h11));
            step();
            n_cmp++;
            if (iq_bus.iq_o_count !== 3'(i) || iq_bus.iq_o_instr !== 32'h11) begin
                n_err++;
                $display("FAIL fill_%0d: got count=%0d head=%h want count=%0d head=11",
                         i, iq_bus.iq_o_count, iq_bus.iq_o_instr, i);
            end
        end
        n_cmp++;
        if (iq_bus.iq_o_full !== 1'b1) begin
            n_err++; $display("FAIL fill_full: got %b want 1", iq_bus.iq_o_full);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if (iq_bus.iq_o_instr !== 32'(i * 32'h11)) begin
                n_err++;
                $display("FAIL drain_%0d: got %h want %h", i, iq_bus.iq_o_instr, 32'(i * 32'h11));
            end
            step();
        end
        n_cmp++;
        if (iq_bus.iq_o_check_queue !== 1'b0 || iq_bus.iq_o_instr !== 32'h0) begin
            n_err++;
            $display("FAIL drain_empty: got cq=%b head=%h want cq=0 head=0",
                     iq_bus.iq_o_check_queue, iq_bus.iq_o_instr);
        end
    endtask

    task automatic test_push_pop();
        drive(1'b1, 1'b1, 1'b0, 32'hA1);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'hA2);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h55);
        n_cmp++;
        if (iq_bus.iq_o_instr !== 32'hA1) begin
            n_err++; $display("FAIL pushpop_head0: got %h want a1", iq_bus.iq_o_instr);
        end
        step();
        n_cmp++;
        if (iq_bus.iq_o_count !== 3'd2 || iq_bus.iq_o_instr !== 32'hA2) begin
            n_err++;
            $display("FAIL pushpop_count: got count=%0d head=%h want count=2 head=a2",
                     iq_bus.iq_o_count, iq_bus.iq_o_instr);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        n_cmp++;
        if (iq_bus.iq_o_count !== 3'd1 || iq_bus.iq_o_instr !== 32'h55) begin
            n_err++;
            $display("FAIL pushpop_order: got count=%0d head=%h want count=1 head=55",
                     iq_bus.iq_o_count, iq_bus.iq_o_instr);
        end
        step();
        n_cmp++;
        if (iq_bus.iq_o_count !== 3'd0) begin
            n_err++; $display("FAIL pushpop_empty: got %0d want 0", iq_bus.iq_o_count);
        end
    endtask

    task automatic test_full_drop();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h60 + 32'(i));
            step();
        end
        drive(1'b1, 1'b1, 1'b0, 32'h99);
        step();
        n_cmp++;
        if (iq_bus.iq_o_count !== 3'd4 || iq_bus.iq_o_full !== 1'b1) begin
            n_err++;
            $display("FAIL drop_count: got count=%0d full=%b want count=4 full=1",
                     iq_bus.iq_o_count, iq_bus.iq_o_full);
        end
`ifdef IQ_OVERFLOW_CHK_EN
        n_cmp++;
        if (iq_bus.iq_o_overflow !== 1'b1) begin
            n_err++; $display("FAIL drop_overflow: got %b want 1", iq_bus.iq_o_overflow);
        end
`endif
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if (iq_bus.iq_o_instr !== 32'h60 + 32'(i)) begin
                n_err++;
                $display("FAIL drop_contents_%0d: got %h want %h",
                         i, iq_bus.iq_o_instr, 32'h60 + 32'(i));
            end
            step();
        end
        n_cmp++;
        if (iq_bus.iq_o_count !== 3'd0) begin
            n_err++; $display("FAIL drop_drained: got %0d want 0", iq_bus.iq_o_count);
        end
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h70 + 32'(i));
            step();
        end
        n_cmp++;
        if (iq_bus.iq_o_count !== 3'd3) begin
            n_err++; $display("FAIL flush_pre: got %0d want 3", iq_bus.iq_o_count);
        end
        drive(1'b1, 1'b0, 1'b1, 32'h88);
        step();
        n_cmp++;
        if (iq_bus.iq_o_count !== 3'd0 || iq_bus.iq_o_check_queue !== 1'b0
            || iq_bus.iq_o_instr !== 32'h0) begin
            n_err++;
            $display("FAIL flush_state: got count=%0d cq=%b head=%h want 0/0/0",
                     iq_bus.iq_o_count, iq_bus.iq_o_check_queue, iq_bus.iq_o_instr);
        end
`ifdef IQ_OVERFLOW_CHK_EN
        n_cmp++;
        if (iq_bus.iq_o_overflow !== 1'b1) begin
            n_err++; $display("FAIL flush_overflow_sticky: got %b want 1", iq_bus.iq_o_overflow);
        end
`endif
        drive(1'b1, 1'b1, 1'b0, 32'hC1);
        step();
        n_cmp++;
        if (iq_bus.iq_o_count !== 3'd1 || iq_bus.iq_o_instr !== 32'hC1) begin
            n_err++;
            $display("FAIL flush_refill: got count=%0d head=%h want count=1 head=c1",
                     iq_bus.iq_o_count, iq_bus.iq_o_instr);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 2; k++) begin
                w = 32'h100 + 32'(2 * r + k);
                drive(1'b1, 1'b1, 1'b0, w);
                step();
            end
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            for (int k = 0; k < 2; k++) begin
                w = 32'h100 + 32'(2 * r + k);
                n_cmp++;
                if (iq_bus.iq_o_instr !== w) begin
                    n_err++;
                    $display("FAIL wrap_r%0d_k%0d: got %h want %h", r, k, iq_bus.iq_o_instr, w);
                end
                step();
            end
        end
        n_cmp++;
        if (iq_bus.iq_o_count !== 3'd0) begin
            n_err++; $display("FAIL wrap_end: got %0d want 0", iq_bus.iq_o_count);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_bypass();
        test_fill_drain();
        test_push_pop();
        test_full_drop();
        test_flush();
        test_wrap();
        // Second reset clears the sticky overflow and any residual state.
        drive(1'b1, 1'b1, 1'b0, 32'hE1);
        step();
        test_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_instr_queue
`default_nettype wire
